// File: rtl/tt_um_hoene_frame_transmitter_pkg.sv
`default_nettype none
// ============================================================================
// tt_um_hoene_frame_transmitter_pkg : shared state encoding and word layout
// Revision 1.0 - initial release
// ============================================================================
package tt_um_hoene_frame_transmitter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LEAD_GAP  = 2'd1,
      ST_DATA      = 2'd2,
      ST_TRAIL_GAP = 2'd3
   } state_t;

   localparam int WORD_BITS   = 32;
   localparam int COLOUR_BITS = 10;
   localparam int PARITY_BIT  = 31;
   localparam int TEST_BIT    = 30;
   localparam int RED_LSB     = 20;
   localparam int GREEN_LSB   = 10;
   localparam int BLUE_LSB    = 0;

   // Parity makes the XOR over all 32 bits zero.
   function automatic logic [WORD_BITS-1:0] pack_word(
      input logic [COLOUR_BITS-1:0] red,
      input logic [COLOUR_BITS-1:0] green,
      input logic [COLOUR_BITS-1:0] blue,
      input logic                   test
   );
      logic [WORD_BITS-1:0] w;
      w                          = '0;
      w[TEST_BIT]                = test;
      w[RED_LSB +: COLOUR_BITS]   = red;
      w[GREEN_LSB +: COLOUR_BITS] = green;
      w[BLUE_LSB +: COLOUR_BITS]  = blue;
      w[PARITY_BIT]              = ^w[TEST_BIT:0];
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tt_um_hoene_halfbit_timer.sv
`default_nettype none
// ============================================================================
// tt_um_hoene_halfbit_timer : one-cycle tick every HALF_PERIOD clocks
// Revision 1.0 - initial release
// ============================================================================
module tt_um_hoene_halfbit_timer
   import tt_um_hoene_frame_transmitter_pkg::*;
#(
   parameter int HALF_PERIOD = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tt_um_hoene_frame_transmitter.sv
`default_nettype none
// ============================================================================
// tt_um_hoene_frame_transmitter : Manchester frame transmitter for LED chain
// Revision 1.0 - initial release
// ============================================================================
module tt_um_hoene_frame_transmitter
   import tt_um_hoene_frame_transmitter_pkg::*;
#(
   parameter int HALF_PERIOD  = 4,
   parameter int GAP_HALFBITS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [9:0] in_red,
   input  logic [9:0] in_green,
   input  logic [9:0] in_blue,
   input  logic       in_test,
   input  logic       in_last,
   output logic       out_data,
   output logic       out_enable,
   output logic       busy,
   output logic       underrun,
   output logic       frame_done
);

   localparam int GAP_W = $clog2(GAP_HALFBITS);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_HALFBITS - 1);

   state_t                state_q, state_d;
   logic [WORD_BITS-1:0] buf_word_q, buf_word_d;
   logic                 buf_last_q, buf_last_d;
   logic                 buf_full_q, buf_full_d;
   logic [WORD_BITS-1:0] shift_q, shift_d;
   logic                 last_q, last_d;
   logic                 half_q, half_d;
   logic [4:0]           bit_idx_q, bit_idx_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic                 out_data_q, out_data_d;
   logic                 out_enable_q, out_enable_d;

   logic tick;
   logic clear;
   logic xfer;
   logic load;
   logic underrun_w;
   logic frame_done_w;

   tt_um_hoene_halfbit_timer #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .tick  (tick)
   );

   always_comb begin
      state_d      = state_q;
      buf_word_d   = buf_word_q;
      buf_last_d   = buf_last_q;
      buf_full_d   = buf_full_q;
      shift_d      = shift_q;
      last_d       = last_q;
      half_d       = half_q;
      bit_idx_d    = bit_idx_q;
      gap_d        = gap_q;
      load         = 1'b0;
      underrun_w   = 1'b0;
      frame_done_w = 1'b0;
      xfer         = in_valid && !buf_full_q;

      case (state_q)
         ST_IDLE: begin
            if (buf_full_q || xfer) begin
               state_d = ST_LEAD_GAP;
            end
         end
         ST_LEAD_GAP: begin
            if (tick) begin
               if (gap_q == GAP_LAST) begin
                  state_d = ST_DATA;
                  load    = 1'b1;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (!half_q) begin
                  half_d = 1'b1;
               end else begin
                  half_d = 1'b0;
                  if (bit_idx_q != 5'd0) begin
                     bit_idx_d = bit_idx_q - 5'd1;
                     shift_d   = shift_q << 1;
                  end else if (last_q) begin
                     state_d = ST_TRAIL_GAP;
                  end else if (buf_full_q) begin
                     load = 1'b1;
                  end else begin
                     underrun_w = 1'b1;
                     state_d    = ST_TRAIL_GAP;
                  end
               end
            end
         end
         ST_TRAIL_GAP: begin
            if (tick) begin
               if (gap_q == GAP_LAST) begin
                  state_d      = ST_IDLE;
                  frame_done_w = 1'b1;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A load only happens with the buffer full, so it never collides with xfer.
      if (load) begin
         shift_d    = buf_word_q;
         last_d     = buf_last_q;
         bit_idx_d  = 5'd31;
         half_d     = 1'b0;
         buf_full_d = 1'b0;
      end
      if (xfer) begin
         buf_full_d = 1'b1;
         buf_word_d = pack_word(in_red, in_green, in_blue, in_test);
         buf_last_d = in_last;
      end
      if (state_d != state_q) begin
         gap_d = '0;
      end

      clear        = (state_d != state_q) || (state_q == ST_IDLE);
      out_enable_d = (state_d != ST_IDLE);
      // Bit 1 is low-then-high, bit 0 high-then-low.
      out_data_d   = (state_d == ST_DATA) ? ~(shift_d[WORD_BITS-1] ^ half_d) : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         buf_word_q   <= '0;
         buf_last_q   <= 1'b0;
         buf_full_q   <= 1'b0;
         shift_q      <= '0;
         last_q       <= 1'b0;
         half_q       <= 1'b0;
         bit_idx_q    <= '0;
         gap_q        <= '0;
         out_data_q   <= 1'b0;
         out_enable_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_word_q   <= buf_word_d;
         buf_last_q   <= buf_last_d;
         buf_full_q   <= buf_full_d;
         shift_q      <= shift_d;
         last_q       <= last_d;
         half_q       <= half_d;
         bit_idx_q    <= bit_idx_d;
         gap_q        <= gap_d;
         out_data_q   <= out_data_d;
         out_enable_q <= out_enable_d;
      end
   end

   assign in_ready   = !buf_full_q;
   assign out_data   = out_data_q;
   assign out_enable = out_enable_q;
   assign busy       = (state_q != ST_IDLE);
   assign underrun   = underrun_w;
   assign frame_done = frame_done_w;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_hoene_frame_transmitter.sv
`default_nettype none
// ============================================================================
// tb_tt_um_hoene_frame_transmitter : randomized frames against a line model
// Revision 1.0 - initial release
// ============================================================================
module tb_tt_um_hoene_frame_transmitter;

   localparam int HP       = 4;
   localparam int GH       = 8;
   localparam int GAP_CYC  = GH * HP;
   localparam int WORD_CYC = 64 * HP;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [9:0] in_red = '0;
   logic [9:0] in_green = '0;
   logic [9:0] in_blue = '0;
   logic       in_test = 1'b0;
   logic       in_last = 1'b0;
   logic       out_data;
   logic       out_enable;
   logic       busy;
   logic       underrun;
   logic       frame_done;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   logic [9:0] f_r[3];
   logic [9:0] f_g[3];
   logic [9:0] f_b[3];
   logic       f_t[3];

   logic trace[$];
   int   fd_cyc;
   int   first_en;
   int   n_und;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tt_um_hoene_frame_transmitter #(
      .HALF_PERIOD  (HP),
      .GAP_HALFBITS (GH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_red     (in_red),
      .in_green   (in_green),
      .in_blue    (in_blue),
      .in_test    (in_test),
      .in_last    (in_last),
      .out_data   (out_data),
      .out_enable (out_enable),
      .busy       (busy),
      .underrun   (underrun),
      .frame_done (frame_done)
   );

   task automatic check(input string tag, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   // Word as it should appear on the line: even parity over all 32 bits.
   function automatic logic [31:0] model_word(input int k);
      logic [31:0] w;
      w     = {1'b0, f_t[k], f_r[k], f_g[k], f_b[k]};
      w[31] = ^w;
      return w;
   endfunction

   task automatic send_word(input int k, input logic last, output int t);
      int waited;
      @(negedge clk);
      in_valid = 1'b1;
      in_red   = f_r[k];
      in_green = f_g[k];
      in_blue  = f_b[k];
      in_test  = f_t[k];
      in_last  = last;
      waited   = 0;
      while (!in_ready && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      check("ready_wait", longint'(waited < 2000), 1);
      t = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic collect();
      int budget;
      budget   = 0;
      fd_cyc   = -1;
      first_en = -1;
      n_und    = 0;
      trace.delete();
      while (fd_cyc < 0 && budget < 5000) begin
         @(negedge clk);
         budget++;
         if (out_enable) begin
            if (first_en < 0) first_en = cyc;
            trace.push_back(out_data);
         end
         if (underrun) n_und++;
         if (frame_done) fd_cyc = cyc;
      end
      check("frame_done_seen", longint'(fd_cyc >= 0), 1);
   endtask

   task automatic run_frame(input int n, input bit starve);
      int          t0;
      int          t;
      int          len;
      int          bad;
      int          rel;
      int          idx;
      logic        e;
      logic        o;
      logic [31:0] w;
      logic [31:0] got;
      t0 = 0;
      fork
         begin
            for (int k = 0; k < n; k++) begin
               send_word(k, (k == n - 1) && !starve, t);
               if (k == 0) t0 = t;
               repeat ($urandom_range(0, 100)) @(negedge clk);
            end
         end
         collect();
      join
      len = 2 * GAP_CYC + n * WORD_CYC;
      check("lead_latency", first_en - t0, 1);
      check("frame_done_time", fd_cyc - t0, len);
      check("enable_cycles", trace.size(), len);
      check("underrun_count", n_und, starve ? 1 : 0);
      bad = 0;
      for (int i = 0; i < len; i++) begin
         e = 1'b0;
         if (i >= GAP_CYC && i < GAP_CYC + n * WORD_CYC) begin
            rel = i - GAP_CYC;
            w   = model_word(rel / WORD_CYC);
            e   = w[31 - (rel % WORD_CYC) / (2 * HP)];
            if ((rel % (2 * HP)) < HP) e = ~e;
         end
         o = (i < trace.size()) ? trace[i] : 1'bx;
         if (o !== e) bad++;
      end
      check("line_bad_cycles", bad, 0);
      for (int k = 0; k < n; k++) begin
         got = '0;
         for (int b = 0; b < 32; b++) begin
            idx = GAP_CYC + k * WORD_CYC + b * 2 * HP + HP;
            got[31 - b] = (idx < trace.size()) ? trace[idx] : 1'b0;
         end
         check($sformatf("decoded_word%0d", k), got, model_word(k));
      end
      @(negedge clk);
      check("idle_after_frame", {busy, out_enable}, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int guard;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_data", out_data, 0);
      check("rst_out_enable", out_enable, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_underrun", underrun, 0);
      check("rst_frame_done", frame_done, 0);
      rst = 1'b0;

      f_r[0] = 10'h3FF; f_g[0] = 10'h000; f_b[0] = 10'h155; f_t[0] = 1'b0;
      run_frame(1, 1'b0);

      f_r[0] = 10'h000; f_g[0] = 10'h000; f_b[0] = 10'h000; f_t[0] = 1'b1;
      check("test_word_model", model_word(0), 32'hC000_0000);
      run_frame(1, 1'b0);

      f_r[0] = 10'h2A5; f_g[0] = 10'h0F0; f_b[0] = 10'h001; f_t[0] = 1'b0;
      run_frame(1, 1'b1);

      for (int fr = 0; fr < 7; fr++) begin
         for (int k = 0; k < 3; k++) begin
            f_r[k] = 10'($urandom);
            f_g[k] = 10'($urandom);
            f_b[k] = 10'($urandom);
            f_t[k] = 1'($urandom);
         end
         run_frame((fr == 0) ? 3 : int'($urandom_range(1, 3)),
                   (fr != 0) && ($urandom_range(0, 3) == 0));
      end

      // Abort in the middle of bit 15.
      f_r[0] = 10'h123; f_g[0] = 10'h321; f_b[0] = 10'h0AA; f_t[0] = 1'b1;
      send_word(0, 1'b1, t);
      guard = 0;
      while (cyc < t + GAP_CYC + 16 * 2 * HP && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      check("pre_abort_busy", busy, 1);
      check("pre_abort_enable", out_enable, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_out_data", out_data, 0);
      check("abort_out_enable", out_enable, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("abort_stays_idle", {busy, out_enable}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
